// File: rtl/ddfs_sweep_ctrl_if.sv
// Config/control/output bundle between the register side and the ddfs_iq sweep sequencer.
interface ddfs_sweep_ctrl_if #(
  parameter int FTW_W   = 8,
  parameter int DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FTW_W-1:0]   cfg_ftw_start;
  logic [FTW_W-1:0]   cfg_ftw_stop;
  logic [FTW_W-1:0]   cfg_ftw_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_cont;
  logic               start;
  logic               abort;
  logic [FTW_W-1:0]   q_ftw;
  logic               ftw_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_ftw_start, cfg_ftw_stop, cfg_ftw_step, cfg_dwell, cfg_cont,
           start, abort,
    input  cfg_ready, q_ftw, ftw_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_ftw_start, cfg_ftw_stop, cfg_ftw_step, cfg_dwell, cfg_cont,
           start, abort,
    output cfg_ready, q_ftw, ftw_valid, busy, done
  );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// Linear FTW sweep sequencer (start/stop/step/dwell, single-shot or continuous) for ddfs_iq.
// Optional DDFS_SWEEP_TRIANGLE_EN: continuous mode bounces between endpoints instead of sawtooth.
module ddfs_sweep_ctrl #(
  parameter int FTW_W   = 8,
  parameter int DWELL_W = 16
) (
  input logic              clk,
  input logic              reset_n,
  ddfs_sweep_ctrl_if.slave sif
);

  // The STEP decision is folded into the last DWELL cycle, so no separate STEP state exists.
  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

  state_t             state;
  logic [FTW_W-1:0]   start_r, stop_r, step_r, target, q;
  logic [DWELL_W-1:0] dwell_r, cnt;
  logic               cont_r, down, ftw_valid_r, busy_r, done_r, cfg_ready_r;

  // Advance toward tgt by stp, saturating at tgt; computed wide so it never wraps.
  function automatic logic [FTW_W-1:0] step_clamp(
    input logic [FTW_W-1:0] cur,
    input logic [FTW_W-1:0] stp,
    input logic [FTW_W-1:0] tgt,
    input logic             dn
  );
    logic signed [FTW_W+1:0] wide;
    logic signed [FTW_W+1:0] wide_tgt;
    wide_tgt = $signed({2'b00, tgt});
    if (dn) wide = $signed({2'b00, cur}) - $signed({2'b00, stp});
    else    wide = $signed({2'b00, cur}) + $signed({2'b00, stp});
    if (dn ? (wide <= wide_tgt) : (wide >= wide_tgt)) return tgt;
    return wide[FTW_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_r     <= '0;
      stop_r      <= '0;
      step_r      <= '0;
      dwell_r     <= '0;
      cont_r      <= 1'b0;
      target      <= '0;
      down        <= 1'b0;
      cnt         <= '0;
      q           <= '0;
      ftw_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      ftw_valid_r <= 1'b0;
      done_r      <= 1'b0;
      if (sif.abort) begin
        state       <= IDLE;
        q           <= '0;
        busy_r      <= 1'b0;
        cfg_ready_r <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (sif.cfg_valid) begin
              start_r <= sif.cfg_ftw_start;
              stop_r  <= sif.cfg_ftw_stop;
              step_r  <= sif.cfg_ftw_step;
              dwell_r <= sif.cfg_dwell;
              cont_r  <= sif.cfg_cont;
            end
            // A sweep launched together with a config write uses the previously latched config.
            if (sif.start) begin
              state       <= LOAD;
              q           <= start_r;
              ftw_valid_r <= 1'b1;
              cnt         <= dwell_r;
              target      <= stop_r;
              down        <= (start_r > stop_r);
              busy_r      <= 1'b1;
              cfg_ready_r <= 1'b0;
            end
          end
          LOAD, DWELL: begin
            state <= DWELL;
            if (cnt != '0) begin
              cnt <= cnt - DWELL_W'(1);
            end else begin
              cnt <= dwell_r;
              if (q == target || step_r == '0) begin
                if (!cont_r) begin
                  state       <= IDLE;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
                  cfg_ready_r <= 1'b1;
                end else begin
                  ftw_valid_r <= 1'b1;
`ifdef DDFS_SWEEP_TRIANGLE_EN
                  // Turn around: the endpoint just held is not re-emitted.
                  target <= (target == stop_r) ? start_r : stop_r;
                  down   <= (q > ((target == stop_r) ? start_r : stop_r));
                  q      <= step_clamp(q, step_r, (target == stop_r) ? start_r : stop_r,
                                       (q > ((target == stop_r) ? start_r : stop_r)));
`else
                  q      <= start_r;
`endif
                end
              end else begin
                q           <= step_clamp(q, step_r, target, down);
                ftw_valid_r <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sif.q_ftw     = q;
  assign sif.ftw_valid = ftw_valid_r;
  assign sif.busy      = busy_r;
  assign sif.done      = done_r;
  assign sif.cfg_ready = cfg_ready_r;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Randomized bench for ddfs_sweep_ctrl against a sequence-level model of the FTW sweep.
module tb_ddfs_sweep_ctrl;
  localparam int FTW_W   = 8;
  localparam int DWELL_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddfs_sweep_ctrl_if #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) sif ();
  ddfs_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sif    (sif)
  );

  int checks = 0;
  int errors = 0;
  int seq[$];
  int eq[$];
  bit ev[$], eb[$], ed[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sif.cfg_valid = 1'b0;
    sif.cfg_ftw_start = '0;
    sif.cfg_ftw_stop = '0;
    sif.cfg_ftw_step = '0;
    sif.cfg_dwell = '0;
    sif.cfg_cont = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int q, input bit v, input bit b, input bit d);
    chk({tag, "_q"}, sif.q_ftw, q);
    chk({tag, "_vld"}, sif.ftw_valid, v);
    chk({tag, "_busy"}, sif.busy, b);
    chk({tag, "_done"}, sif.done, d);
    chk({tag, "_rdy"}, sif.cfg_ready, !b);
  endtask

  // Values visited walking from 'from' to 'to' in stp increments, saturating at 'to'.
  function automatic int append_walk(input int from, input int to, input int stp, input bit skip_first);
    int v = from;
    int n = 0;
    if (!skip_first) begin seq.push_back(v); n++; end
    while (v != to && stp != 0) begin
      if (to > v) v = (v + stp >= to) ? to : v + stp;
      else        v = (v - stp <= to) ? to : v - stp;
      seq.push_back(v);
      n++;
    end
    return n;
  endfunction

  task automatic build_model(input int st, input int sp, input int stp, input int dw,
                             input bit cont, input int ncyc);
    int n;
    int a, b, tmp;
    seq.delete(); eq.delete(); ev.delete(); eb.delete(); ed.delete();
    if (!cont) begin
      n = append_walk(st, sp, stp, 1'b0);
    end else begin
      n = append_walk(st, sp, stp, 1'b0);
      a = st; b = sp;
      while (seq.size() * (dw + 1) < ncyc) begin
`ifdef DDFS_SWEEP_TRIANGLE_EN
        tmp = a; a = b; b = tmp;
        n = append_walk(a, b, stp, 1'b1);
        if (n == 0) seq.push_back(a);
`else
        n = append_walk(st, sp, stp, 1'b0);
`endif
      end
    end
    foreach (seq[k]) begin
      for (int c = 0; c <= dw; c++) begin
        eq.push_back(seq[k]); ev.push_back(c == 0); eb.push_back(1'b1); ed.push_back(1'b0);
      end
    end
    if (cont) begin
      while (eq.size() > ncyc) begin
        void'(eq.pop_back()); void'(ev.pop_back()); void'(eb.pop_back()); void'(ed.pop_back());
      end
    end else begin
      eq.push_back(seq[$]); ev.push_back(1'b0); eb.push_back(1'b0); ed.push_back(1'b1);
    end
  endtask

  task automatic configure(input int st, input int sp, input int stp, input int dw, input bit cont);
    chk("cfg_ready_idle", sif.cfg_ready, 1);
    sif.cfg_ftw_start = st[FTW_W-1:0];
    sif.cfg_ftw_stop  = sp[FTW_W-1:0];
    sif.cfg_ftw_step  = stp[FTW_W-1:0];
    sif.cfg_dwell     = dw[DWELL_W-1:0];
    sif.cfg_cont      = cont;
    sif.cfg_valid     = 1'b1;
    tick();
    sif.cfg_valid     = 1'b0;
  endtask

  // Runs one sweep; continuous sweeps are cut after ncyc cycles with abort (and a competing start).
  task automatic run_sweep(input string tag, input bit do_cfg, input int st, input int sp,
                           input int stp, input int dw, input bit cont, input int ncyc,
                           input bit noise);
    if (do_cfg) configure(st, sp, stp, dw, cont);
    build_model(st, sp, stp, dw, cont, ncyc);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    foreach (eq[i]) begin
      check_outputs(tag, eq[i], ev[i], eb[i], ed[i]);
      if (noise && eb[i]) begin
        sif.cfg_valid     = 1'($urandom_range(0, 1));
        sif.start         = 1'($urandom_range(0, 1));
        sif.cfg_ftw_start = 8'($urandom);
        sif.cfg_ftw_stop  = 8'($urandom);
        sif.cfg_ftw_step  = 8'($urandom);
        sif.cfg_dwell     = 16'($urandom_range(0, 5));
        sif.cfg_cont      = 1'($urandom_range(0, 1));
      end else begin
        sif.cfg_valid = 1'b0;
        sif.start     = 1'b0;
      end
      tick();
    end
    sif.cfg_valid = 1'b0;
    if (cont) begin
      sif.abort = 1'b1;
      sif.start = 1'b1;
      tick();
      sif.abort = 1'b0;
      sif.start = 1'b0;
      check_outputs({tag, "_abort"}, 0, 1'b0, 1'b0, 1'b0);
      tick();
      check_outputs({tag, "_postabort"}, 0, 1'b0, 1'b0, 1'b0);
    end else begin
      sif.start = 1'b0;
      check_outputs({tag, "_idle"}, seq[$], 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int st, sp, stp, dw, nc;
    bit cont;
    clear_inputs();
    reset_n = 1'b0;
    repeat (3) tick();
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();

    // Directed: upward single shot with dwell, downward with clamp, continuous full range.
    run_sweep("up10", 1'b1, 10, 40, 10, 2, 1'b0, 0, 1'b0);
    run_sweep("down3", 1'b1, 200, 190, 3, 0, 1'b0, 0, 1'b0);
    run_sweep("cont_full", 1'b1, 0, 255, 100, 0, 1'b1, 14, 1'b0);
    run_sweep("cont_dn", 1'b1, 255, 0, 100, 1, 1'b1, 20, 1'b0);

    // start==stop: one value, config writes during busy ignored, rerun on latched config.
    run_sweep("same77", 1'b1, 77, 77, 5, 4, 1'b0, 0, 1'b1);
    run_sweep("same77_again", 1'b0, 77, 77, 5, 4, 1'b0, 0, 1'b0);
    run_sweep("step0", 1'b1, 20, 90, 0, 1, 1'b0, 0, 1'b0);

    // Reset mid-sweep restores outputs and clears the latched config.
    configure(10, 200, 1, 0, 1'b0);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      check_outputs("rst_mid", 0, 1'b0, 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    run_sweep("after_rst", 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      st   = $urandom_range(0, 255);
      sp   = (t % 5 == 0) ? st : $urandom_range(0, 255);
      cont = 1'($urandom_range(0, 1));
      stp  = cont ? $urandom_range(1, 60) : $urandom_range(0, 60);
      dw   = $urandom_range(0, 3);
      nc   = $urandom_range(30, 80);
      run_sweep($sformatf("rnd%0d", t), 1'b1, st, sp, stp, dw, cont, nc, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1, "timeout");
  end
endmodule
